fir_upsampler: RTL and testbench

Rate-conversion front end for the interpolating FIR. It buffers incoming PCM samples, which arrive at the base rate from the serial audio receiver, in a small FIFO. It generates the FIR's `sample_ready` strobe at the oversampled rate and presents each buffered sample followed by `ratio-1` zeros (zero-stuffing interpolation). Its `sample` and `sample_ready` outputs connect directly to the FIR's `sample` and `sample_ready` inputs. Interpolation gain is carried by the FIR coefficients; this block applies no gain.

---
 rtl/fir_upsampler.sv | 160 ++++++++++++++++
 tb/tb_fir_upsampler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_upsampler.sv
// fir_upsampler: base-rate sample FIFO feeding a zero-stuffing
// interpolator that strobes the FIR once every `period` clocks.
module fir_upsampler #(
    parameter int bits      = 16,
    parameter int ratio     = 2,
    parameter int period    = 64,
    parameter int fifo_bits = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [bits-1:0]      in_sample,
    input  logic                 in_valid,
    input  logic                 clear_flags,
    output logic [bits-1:0]      sample,
    output logic                 sample_ready,
    output logic [fifo_bits:0]   fifo_level,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int depth = 1 << fifo_bits;
    localparam int tw    = (period > 1) ? $clog2(period) : 1;
    localparam int pw    = (ratio > 1) ? $clog2(ratio) : 1;

    localparam logic [fifo_bits:0] lvl_full = (fifo_bits + 1)'(depth);
    localparam logic [fifo_bits:0] lvl_half = (fifo_bits + 1)'(depth / 2);
    localparam logic [tw-1:0]      tc_last  = tw'(period - 1);
    localparam logic [pw-1:0]      ph_last  = pw'(ratio - 1);

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [tw-1:0]        tc;
    logic [pw-1:0]        ph;
    logic [bits-1:0]      mem [depth];
    logic [fifo_bits-1:0] wr_ptr;
    logic [fifo_bits-1:0] rd_ptr;

    logic tick;
    logic ph_zero;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic oflow_evt;
    logic uflow_evt;

    assign tick    = (tc == tc_last);
    assign ph_zero = (ph == '0);
    assign full    = (fifo_level == lvl_full);
    assign empty   = (fifo_level == '0);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push      = in_valid && (!full || pop);
    assign oflow_evt = in_valid && full && !pop;

    // Next state: prime until half full, pop on phase-0 ticks in RUN.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        uflow_evt = 1'b0;
        unique case (state_q)
            PRIME: begin
                if (fifo_level >= lvl_half) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick && ph_zero) begin
                    if (empty) begin
                        uflow_evt = 1'b1;
                        state_d   = PRIME;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-rate tick counter and interpolation phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc <= '0;
            ph <= '0;
        end else if (tick) begin
            tc <= '0;
            ph <= (ph == ph_last) ? '0 : ph + 1'b1;
        end else begin
            tc <= tc + 1'b1;
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Strobe and zero-stuffed sample toward the FIR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= '0;
            sample_ready <= 1'b0;
        end else begin
            sample_ready <= tick;
            if (tick) begin
                sample <= pop ? mem[rd_ptr] : '0;
            end
        end
    end

    // Sticky flags; a same-edge event wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= oflow_evt | (overflow & ~clear_flags);
            underflow <= uflow_evt | (underflow & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_fir_upsampler.sv
// tb_fir_upsampler: directed checks of strobe timing, priming,
// zero stuffing, FIFO limits, sticky flags and async reset.
module tb_fir_upsampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_sample = '0;
    logic        in_valid = 1'b0;
    logic        clear_flags = 1'b0;
    logic [15:0] sample;
    logic        sample_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        underflow;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    fir_upsampler #(
        .bits(16),
        .ratio(2),
        .period(64),
        .fifo_bits(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_sample(in_sample),
        .in_valid(in_valid),
        .clear_flags(clear_flags),
        .sample(sample),
        .sample_ready(sample_ready),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic push(input logic [15:0] d);
        in_valid  = 1'b1;
        in_sample = d;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        clear_flags = 1'b0;
        in_sample   = '0;
        #20;
        chk("rst_sample", 32'(sample), 32'h0);
        chk("rst_ready", 32'(sample_ready), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_oflow", 32'(overflow), 32'h0);
        chk("rst_uflow", 32'(underflow), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic strobe(input int n, input logic [15:0] exp,
                          input string tag);
        run_to(n - 1);
        chk($sformatf("%s_pre@%0d", tag, n), 32'(sample_ready), 32'h0);
        step();
        chk($sformatf("%s_rdy@%0d", tag, n), 32'(sample_ready), 32'h1);
        chk($sformatf("%s_smp@%0d", tag, n), 32'(sample), 32'(exp));
    endtask

    initial begin
        logic [15:0] e;

        // Idle: strobes every 64 cycles, zero samples, no flags.
        do_reset();
        for (int k = 1; k <= 1000; k++) begin
            step();
            chk("s1_rdy", 32'(sample_ready), 32'((cyc % 64) == 0));
            chk("s1_smp", 32'(sample), 32'h0);
        end
        chk("s1_oflow", 32'(overflow), 32'h0);
        chk("s1_uflow", 32'(underflow), 32'h0);
        chk("s1_level", 32'(fifo_level), 32'h0);

        // Two samples: prime, play with zero stuffing, underflow.
        do_reset();
        push(16'h1234);
        push(16'h5678);
        chk("s2_level2", 32'(fifo_level), 32'h2);
        strobe(64, 16'h1234, "s2");
        chk("s2_level1", 32'(fifo_level), 32'h1);
        step();
        chk("s2_hold_rdy", 32'(sample_ready), 32'h0);
        chk("s2_hold_smp", 32'(sample), 32'h1234);
        strobe(128, 16'h0000, "s2");
        strobe(192, 16'h5678, "s2");
        chk("s2_level0", 32'(fifo_level), 32'h0);
        strobe(256, 16'h0000, "s2");
        chk("s2_uflow0", 32'(underflow), 32'h0);
        strobe(320, 16'h0000, "s2");
        chk("s2_uflow1", 32'(underflow), 32'h1);
        push(16'h9abc);
        chk("s2_prime_lvl", 32'(fifo_level), 32'h1);
        strobe(384, 16'h0000, "s2p");
        strobe(448, 16'h0000, "s2p");
        chk("s2_prime_hold", 32'(fifo_level), 32'h1);
        chk("s2_uflow_sticky", 32'(underflow), 32'h1);

        // Six pushes: saturate at 4, overflow, first four play out.
        do_reset();
        for (int i = 0; i < 4; i++) push(16'ha000 + 16'(i));
        chk("s3_full", 32'(fifo_level), 32'h4);
        chk("s3_oflow0", 32'(overflow), 32'h0);
        push(16'ha004);
        push(16'ha005);
        chk("s3_sat", 32'(fifo_level), 32'h4);
        chk("s3_oflow1", 32'(overflow), 32'h1);
        for (int k = 0; k < 9; k++) begin
            e = (k % 2 == 0 && k < 8) ? 16'ha000 + 16'(k / 2) : 16'h0;
            strobe(64 * (k + 1), e, "s3");
        end
        chk("s3_uflow", 32'(underflow), 32'h1);
        chk("s3_empty", 32'(fifo_level), 32'h0);

        // Full FIFO with a push on the pop edge: accepted, in order.
        do_reset();
        for (int i = 0; i < 4; i++) push(16'hb000 + 16'(i));
        chk("s4_full", 32'(fifo_level), 32'h4);
        run_to(63);
        in_valid  = 1'b1;
        in_sample = 16'hb004;
        strobe(64, 16'hb000, "s4");
        in_valid  = 1'b0;
        chk("s4_level", 32'(fifo_level), 32'h4);
        chk("s4_oflow", 32'(overflow), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            e = (k % 2 == 0 && k <= 8) ? 16'hb000 + 16'(k / 2) : 16'h0;
            strobe(64 * (k + 1), e, "s4");
        end
        chk("s4_uflow", 32'(underflow), 32'h1);
        chk("s4_oflow_end", 32'(overflow), 32'h0);

        // Overflow set wins over a coincident clear.
        do_reset();
        for (int i = 0; i < 5; i++) push(16'hd000 + 16'(i));
        chk("s5_oflow_set", 32'(overflow), 32'h1);
        in_valid    = 1'b1;
        in_sample   = 16'hd005;
        clear_flags = 1'b1;
        step();
        in_valid    = 1'b0;
        chk("s5_set_wins", 32'(overflow), 32'h1);
        step();
        clear_flags = 1'b0;
        chk("s5_cleared", 32'(overflow), 32'h0);
        chk("s5_level", 32'(fifo_level), 32'h4);

        // Short async reset mid-RUN with three queued samples.
        do_reset();
        for (int i = 0; i < 5; i++) push(16'he000 + 16'(i));
        strobe(64, 16'he000, "s6");
        chk("s6_level3", 32'(fifo_level), 32'h3);
        chk("s6_oflow", 32'(overflow), 32'h1);
        run_to(70);
        #1;
        rst = 1'b1;
        #2;
        chk("s6_async_smp", 32'(sample), 32'h0);
        chk("s6_async_rdy", 32'(sample_ready), 32'h0);
        chk("s6_async_lvl", 32'(fifo_level), 32'h0);
        chk("s6_async_of", 32'(overflow), 32'h0);
        chk("s6_async_uf", 32'(underflow), 32'h0);
        #1;
        rst = 1'b0;
        cyc = 0;
        strobe(64, 16'h0000, "s6r");
        chk("s6_rel_lvl", 32'(fifo_level), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
